// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: redirect input, instruction-memory request/response channel and decode output.
// The master side is the fetch unit; the slave side is the surrounding core/memory.
interface fetch_unit_if #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
);
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              out_valid;
  logic [ADDR_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;
  logic              out_ready;
  logic              fetch_misalign;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output out_valid, out_pc, out_inst,
    input  out_ready,
    output fetch_misalign
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  out_valid, out_pc, out_inst,
    output out_ready,
    input  fetch_misalign
  );
endinterface

// File: rtl/fetch_unit.sv
// Credit-based instruction fetch unit with an in-order fetch queue and redirect flush.
// Optional macro FETCH_MISALIGN_CHK_EN: misaligned redirects halt fetch and raise fetch_misalign.
module fetch_unit #(
  parameter int                ADDR_W   = 64,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                FQ_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_rsp_pc;
  logic [CNT_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic [ADDR_W-1:0] r_q_pc   [FQ_DEPTH];
  logic [INST_W-1:0] r_q_inst [FQ_DEPTH];

  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_inflight;
  logic [ADDR_W-1:0] w_redir_pc;
  logic              w_empty;
  logic              w_credit_ok;
  logic              w_halt;
  logic              w_req_valid;
  logic              w_req_fire;
  logic              w_rsp_drop;
  logic              w_rsp_push;
  logic              w_pop;

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_misalign;
  assign w_redir_pc         = bus.redirect_pc;
  assign w_halt             = r_misalign;
  assign bus.fetch_misalign = r_misalign;
`else
  assign w_redir_pc         = bus.redirect_pc & ~ADDR_W'(3);
  assign w_halt             = 1'b0;
  assign bus.fetch_misalign = 1'b0;
`endif

  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_inflight = r_drop_cnt + r_outstanding;
  // Every outstanding request must have a guaranteed slot when its response lands.
  assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, w_count}) < (CNT_W + 1)'(FQ_DEPTH);

  assign w_req_valid = !rst && !bus.redirect_valid && !w_halt && w_credit_ok;
  assign w_req_fire  = w_req_valid && bus.imem_req_ready;
  assign w_rsp_drop  = bus.imem_rsp_valid && (r_drop_cnt != '0);
  assign w_rsp_push  = bus.imem_rsp_valid && (r_drop_cnt == '0) && (r_outstanding != '0);
  assign w_pop       = !w_empty && bus.out_ready;

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.out_valid      = !w_empty;
  assign bus.out_pc         = w_empty ? '0 : r_q_pc[r_rd_ptr[PTR_W-1:0]];
  assign bus.out_inst       = w_empty ? '0 : r_q_inst[r_rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
      r_misalign    <= 1'b0;
`endif
    end else if (bus.redirect_valid) begin
      r_pc          <= w_redir_pc;
      r_rsp_pc      <= w_redir_pc;
      r_rd_ptr      <= r_wr_ptr;
      r_outstanding <= '0;
      // Stale in-flight responses (older drops included) are all discarded; one may land right now.
      r_drop_cnt    <= (bus.imem_rsp_valid && (w_inflight != '0)) ? w_inflight - CNT_W'(1) : w_inflight;
`ifdef FETCH_MISALIGN_CHK_EN
      r_misalign    <= (bus.redirect_pc[1:0] != 2'b00);
`endif
    end else begin
      if (w_req_fire) r_pc <= r_pc + ADDR_W'(4);
      if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - CNT_W'(1);
      if (w_rsp_push) begin
        r_rsp_pc <= r_rsp_pc + ADDR_W'(4);
        r_wr_ptr <= r_wr_ptr + CNT_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + CNT_W'(1);
      r_outstanding <= r_outstanding + CNT_W'(w_req_fire) - CNT_W'(w_rsp_push);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !bus.redirect_valid && w_rsp_push) begin
      r_q_pc[r_wr_ptr[PTR_W-1:0]]   <= r_rsp_pc;
      r_q_inst[r_wr_ptr[PTR_W-1:0]] <= bus.imem_rsp_data;
    end
  end

  // A response with nothing in flight means the memory broke the in-order contract; it is ignored.
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
    (bus.imem_rsp_valid && !bus.redirect_valid) |-> (r_drop_cnt != '0 || r_outstanding != '0));
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed redirect/backpressure/reset scenarios against a queue-based memory model.
module tb_fetch_unit;
  localparam int          ADDR_W   = 64;
  localparam int          INST_W   = 32;
  localparam int          FQ_DEPTH = 4;
  localparam logic [63:0] RST_PC   = 64'h0000_0000_8000_0000;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_ready;
  logic mem_hold;
  int   fire_cnt;
  int   total = 0;
  int   bad   = 0;
  exp_t        exp_q[$];
  logic [63:0] mem_q[$];

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus();

  fetch_unit #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC(RST_PC), .FQ_DEPTH(FQ_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  assign bus.imem_req_ready = mem_ready;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic expect_pc(input logic [63:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = mem_word(pc);
    exp_q.push_back(e);
  endtask

  // Called at posedge+1: runs until every expected instruction was popped, then stops decode.
  task automatic drain(input string name);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 60) begin
      tick();
      i++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d instructions still pending, want 0", name, exp_q.size());
      exp_q.delete();
    end
    bus.out_ready = 1'b0;
  endtask

  // Memory model: in-order, one-cycle latency, responses held back while mem_hold=1.
  initial begin
    logic        f, c, r;
    logic [63:0] a;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      f = bus.imem_req_valid && bus.imem_req_ready;
      a = bus.imem_req_addr;
      c = bus.imem_rsp_valid;
      r = rst;
      if (f) fire_cnt++;
      @(posedge clk);
      #2;
      if (r) mem_q.delete();
      else begin
        if (c && mem_q.size() > 0) void'(mem_q.pop_front());
        if (f) mem_q.push_back(a);
      end
      bus.imem_rsp_valid = !mem_hold && (mem_q.size() > 0);
      bus.imem_rsp_data  = (mem_q.size() > 0) ? mem_word(mem_q[0]) : '0;
    end
  end

  // Monitor: every decode handshake outside a redirect cycle must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && !bus.redirect_valid && bus.out_valid && bus.out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pop: got pc=%h inst=%h, want no instruction", bus.out_pc, bus.out_inst);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_pc !== e.pc || bus.out_inst !== e.inst) begin
            bad++;
            $display("FAIL out_pop: got pc=%h inst=%h, want pc=%h inst=%h", bus.out_pc, bus.out_inst, e.pc, e.inst);
          end else begin
            $display("ok   out_pop: pc=%h inst=%h", bus.out_pc, bus.out_inst);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
    mem_ready          = 1'b1;
    mem_hold           = 1'b0;
    fire_cnt           = 0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_req_valid", bus.imem_req_valid, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_pc", bus.out_pc, 0);
    check("rst_out_inst", bus.out_inst, 0);
    check("rst_misalign", bus.fetch_misalign, 0);

    // Reset release: back-to-back requests, first output two cycles after first request
    tick();
    for (int i = 0; i < 5; i++) expect_pc(64'h8000_0000 + 64'(4 * i));
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("s1_req_valid", bus.imem_req_valid, 1);
    check("s1_addr0", bus.imem_req_addr, 64'h8000_0000);
    check("s1_out_valid_c0", bus.out_valid, 0);
    tick();
    @(negedge clk);
    check("s1_addr1", bus.imem_req_addr, 64'h8000_0004);
    check("s1_out_valid_c1", bus.out_valid, 0);
    tick();
    @(negedge clk);
    check("s1_addr2", bus.imem_req_addr, 64'h8000_0008);
    check("s1_out_valid_c2", bus.out_valid, 1);
    check("s1_out_pc_c2", bus.out_pc, 64'h8000_0000);
    tick();
    drain("s1");

    // Decode stalled: exactly FQ_DEPTH requests, then none until a pop
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h1000;
    fire_cnt           = 0;
    @(negedge clk);
    check("s2_redirect_req_valid", bus.imem_req_valid, 0);
    tick();
    bus.redirect_valid = 1'b0;
    repeat (9) tick();
    @(negedge clk);
    check("s2_fire_cnt", 64'(fire_cnt), 4);
    check("s2_req_valid_full", bus.imem_req_valid, 0);
    check("s2_out_valid", bus.out_valid, 1);
    check("s2_out_pc", bus.out_pc, 64'h1000);
    tick();
    for (int i = 0; i < 6; i++) expect_pc(64'h1000 + 64'(4 * i));
    bus.out_ready = 1'b1;
    drain("s2");

    // Redirect with two requests outstanding: both responses dropped
    mem_ready          = 1'b0;
    mem_hold           = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h3000;
    tick();
    bus.redirect_valid = 1'b0;
    mem_ready          = 1'b1;
    @(negedge clk);
    check("s3_req_valid0", bus.imem_req_valid, 1);
    check("s3_addr0", bus.imem_req_addr, 64'h3000);
    tick();
    @(negedge clk);
    check("s3_addr1", bus.imem_req_addr, 64'h3004);
    tick();
    mem_ready          = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h100;
    tick();
    bus.redirect_valid = 1'b0;
    mem_hold           = 1'b0;
    mem_ready          = 1'b1;
    bus.out_ready      = 1'b1;
    for (int i = 0; i < 3; i++) expect_pc(64'h100 + 64'(4 * i));
    drain("s3");

    // Redirect colliding with a response and a pop: queue empties, no push
    tick();
    mem_hold = 1'b1;
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h4000;
    mem_hold           = 1'b0;
    bus.out_ready      = 1'b1;
    @(negedge clk);
    check("s4_out_valid_before", bus.out_valid, 1);
    check("s4_redirect_req_valid", bus.imem_req_valid, 0);
    tick();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) expect_pc(64'h4000 + 64'(4 * i));
    @(negedge clk);
    check("s4_out_valid_after", bus.out_valid, 0);
    check("s4_req_valid", bus.imem_req_valid, 1);
    check("s4_addr", bus.imem_req_addr, 64'h4000);
    tick();
    drain("s4");

    // PC wrap-around at the top of the address space
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    bus.out_ready      = 1'b1;
    expect_pc(64'hFFFF_FFFF_FFFF_FFFC);
    expect_pc(64'h0);
    expect_pc(64'h4);
    tick();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("s5_addr_top", bus.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    @(negedge clk);
    check("s5_addr_wrap", bus.imem_req_addr, 64'h0);
    tick();
    drain("s5");

    // Misaligned redirect
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h102;
    tick();
    bus.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    @(negedge clk);
    check("s6_misalign_set", bus.fetch_misalign, 1);
    check("s6_halt_req_valid", bus.imem_req_valid, 0);
    repeat (4) tick();
    @(negedge clk);
    check("s6_halt_req_valid_late", bus.imem_req_valid, 0);
    check("s6_halt_out_valid", bus.out_valid, 0);
    check("s6_misalign_hold", bus.fetch_misalign, 1);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h200;
    tick();
    bus.redirect_valid = 1'b0;
    bus.out_ready      = 1'b1;
    expect_pc(64'h200);
    expect_pc(64'h204);
    @(negedge clk);
    check("s6_misalign_clr", bus.fetch_misalign, 0);
    check("s6_req_valid", bus.imem_req_valid, 1);
    check("s6_addr", bus.imem_req_addr, 64'h200);
    tick();
    drain("s6");
`else
    @(negedge clk);
    check("s6_misalign_tied", bus.fetch_misalign, 0);
    check("s6_req_valid", bus.imem_req_valid, 1);
    check("s6_addr_aligned", bus.imem_req_addr, 64'h100);
    tick();
    bus.out_ready = 1'b1;
    expect_pc(64'h100);
    expect_pc(64'h104);
    drain("s6");
`endif

    // Reset mid-operation abandons everything in flight
    tick();
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("s7_rst_out_valid", bus.out_valid, 0);
    check("s7_rst_out_pc", bus.out_pc, 0);
    check("s7_rst_out_inst", bus.out_inst, 0);
    check("s7_rst_req_valid", bus.imem_req_valid, 0);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    expect_pc(64'h8000_0000);
    expect_pc(64'h8000_0004);
    @(negedge clk);
    check("s7_req_valid", bus.imem_req_valid, 1);
    check("s7_addr0", bus.imem_req_addr, 64'h8000_0000);
    tick();
    drain("s7");

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
